// File: rtl/if_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_fetch_unit : instruction-fetch producer feeding the IF/ID register
// Revision      : 1.0
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             StaF,
  input  logic             PCSrcD,
  input  logic [31:0]      PCBranchD,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instructionF,
  output logic [31:0]      pcplus4F,
  output logic             FetchValid,
  output logic [CNT_W-1:0] BubbleCnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_buf_instr, r_buf_pcp4;
  logic        w_buf_load, w_buf_clr;
  logic [CNT_W-1:0] r_bubble_cnt;

  wire [31:0] w_pc_plus4  = r_pc + 32'd4;
  wire [31:0] w_redirect  = PCBranchD & ~32'h3;

  assign imem_addr = r_pc;
  assign BubbleCnt = r_bubble_cnt;

  // Redirect wins over any ack or held instruction in both fetching states.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_buf_load   = 1'b0;
    w_buf_clr    = 1'b0;
    imem_req     = 1'b0;
    instructionF = 32'h0;
    pcplus4F     = 32'h0;
    FetchValid   = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        imem_req = 1'b1;
        if (PCSrcD) begin
          w_pc_nxt = w_redirect;
        end else if (imem_ack) begin
          w_pc_nxt = w_pc_plus4;
          if (StaF) begin
            w_buf_load  = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            FetchValid   = 1'b1;
            instructionF = imem_rdata;
            pcplus4F     = w_pc_plus4;
          end
        end
      end
      ST_HOLD: begin
        if (PCSrcD) begin
          w_pc_nxt    = w_redirect;
          w_buf_clr   = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          FetchValid   = 1'b1;
          instructionF = r_buf_instr;
          pcplus4F     = r_buf_pcp4;
          if (!StaF) begin
            w_buf_clr   = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC & ~32'h3;
      r_buf_instr <= 32'h0;
      r_buf_pcp4  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_buf_load) begin
        r_buf_instr <= imem_rdata;
        r_buf_pcp4  <= w_pc_plus4;
      end else if (w_buf_clr) begin
        r_buf_instr <= 32'h0;
        r_buf_pcp4  <= 32'h0;
      end
    end
  end

  // Saturating count of bubble cycles once out of BOOT.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_bubble_cnt <= '0;
    end else if (r_state != ST_BOOT && !FetchValid && !(&r_bubble_cnt)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_fetch_unit : randomized fetch-unit bench with a behavioural reference
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK, RST_n, StaF, PCSrcD, imem_req, imem_ack, FetchValid;
  logic [31:0]   PCBranchD, imem_addr, imem_rdata, instructionF, pcplus4F;
  logic [CW-1:0] BubbleCnt;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_n(RST_n), .StaF(StaF), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instructionF(instructionF), .pcplus4F(pcplus4F),
    .FetchValid(FetchValid), .BubbleCnt(BubbleCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model: where the fetcher is, whether an instruction is parked
  bit          m_booted, m_hold;
  logic [31:0] m_pc, m_bi, m_bp;
  int          m_cnt;
  logic        e_req, e_fv;
  logic [31:0] e_ins, e_p4;

  // memory responder state
  bit          trk_v;
  logic [31:0] trk_a;
  int          wc, wn, wmin, wmax, sta_pct, pcs_pct;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h10) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_booted = 0; m_hold = 0; m_pc = 32'h0; m_bi = 32'h0; m_bp = 32'h0; m_cnt = 0;
  endtask

  task automatic calc_exp();
    e_req = 0; e_fv = 0; e_ins = 32'h0; e_p4 = 32'h0;
    if (RST_n && m_booted) begin
      if (m_hold) begin
        if (!PCSrcD) begin e_fv = 1; e_ins = m_bi; e_p4 = m_bp; end
      end else begin
        e_req = 1;
        if (imem_ack && !StaF && !PCSrcD) begin
          e_fv = 1; e_ins = memfn(m_pc); e_p4 = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic model_update();
    if (!RST_n) begin
      model_reset();
    end else if (!m_booted) begin
      m_booted = 1;
    end else begin
      calc_exp();
      if (!e_fv && m_cnt < CMAX) m_cnt++;
      if (PCSrcD) begin
        m_pc = PCBranchD & ~32'h3; m_hold = 0;
      end else if (m_hold) begin
        if (!StaF) m_hold = 0;
      end else if (imem_ack) begin
        if (StaF) begin m_hold = 1; m_bi = memfn(m_pc); m_bp = m_pc + 32'd4; end
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // every cycle, compare DUT against the model away from the active edge
  always @(negedge CLK) begin
    calc_exp();
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("FetchValid", {31'b0, FetchValid}, {31'b0, e_fv});
    chk("instructionF", instructionF, e_ins);
    chk("pcplus4F", pcplus4F, e_p4);
    chk("BubbleCnt", {{(32-CW){1'b0}}, BubbleCnt}, 32'(m_cnt));
  end

  // one clock: update model at the edge, drive inputs just after, settle
  task automatic step(input int sta, input int pcs, input logic [31:0] tgt);
    @(posedge CLK);
    model_update();
    #1;
    StaF      = (sta < 0) ? ($urandom_range(0, 99) < sta_pct) : sta[0];
    PCSrcD    = (pcs < 0) ? ($urandom_range(0, 99) < pcs_pct) : pcs[0];
    PCBranchD = tgt;
    if (imem_req) begin
      if (!trk_v || trk_a != imem_addr) begin
        trk_v = 1; trk_a = imem_addr; wc = 0; wn = $urandom_range(wmin, wmax);
      end
      imem_ack   = (wc >= wn);
      imem_rdata = imem_ack ? memfn(imem_addr) : $urandom;
      wc++;
      if (imem_ack) trk_v = 0;
    end else begin
      trk_v = 0; imem_ack = 1'b0; imem_rdata = $urandom;
    end
    #2;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    model_update();
    #1;
    RST_n = 1'b0; StaF = 1'b0; PCSrcD = 1'b0; imem_ack = 1'b0; trk_v = 0;
    model_reset();
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, FetchValid}, 32'd0);
    chk("rst_cnt", {{(32-CW){1'b0}}, BubbleCnt}, 32'd0);
    @(posedge CLK);
    model_update();
    #1;
    RST_n = 1'b1;
    #2;
    chk("boot_req", {31'b0, imem_req}, 32'd0);
  endtask

  initial begin
    RST_n = 1'b1; StaF = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    trk_v = 0; trk_a = 32'h0; wc = 0; wn = 0; wmin = 0; wmax = 0; sta_pct = 0; pcs_pct = 0;
    model_reset();
    #1 RST_n = 1'b0;
    #2;
    chk("reset_valid", {31'b0, FetchValid}, 32'd0);
    chk("reset_instr", instructionF, 32'd0);
    chk("reset_cnt", {{(32-CW){1'b0}}, BubbleCnt}, 32'd0);
    @(posedge CLK); model_update(); #1 RST_n = 1'b1; #2;

    // zero-wait memory: one instruction per cycle from address 0
    step(0, 0, 32'h0);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_pcp4", pcplus4F, 32'h4);
    step(0, 0, 32'h0);
    chk("second_addr", imem_addr, 32'h4);
    chk("second_pcp4", pcplus4F, 32'h8);
    repeat (6) step(0, 0, 32'h0);
    chk("nobubble_cnt", {{(32-CW){1'b0}}, BubbleCnt}, 32'd0);

    // stall on the instruction at 0x10
    step(0, 1, 32'h10);
    step(1, 0, 32'h0);
    chk("stall_ack_valid", {31'b0, FetchValid}, 32'd0);
    step(1, 0, 32'h0);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_instr", instructionF, 32'h8C01_0004);
    chk("hold_pcp4", pcplus4F, 32'h14);
    step(1, 0, 32'h0);
    chk("hold_instr2", instructionF, 32'h8C01_0004);
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);
    chk("after_hold_addr", imem_addr, 32'h14);

    // redirect with a same-cycle ack
    step(0, 1, 32'h43);
    chk("redir_valid", {31'b0, FetchValid}, 32'd0);
    step(0, 0, 32'h0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_pcp4", pcplus4F, 32'h44);

    // redirect while holding drops the buffered instruction
    step(1, 0, 32'h0);
    step(1, 0, 32'h0);
    step(1, 1, 32'h200);
    chk("holdredir_valid", {31'b0, FetchValid}, 32'd0);
    step(0, 0, 32'h0);
    chk("holdredir_addr", imem_addr, 32'h200);
    chk("holdredir_pcp4", pcplus4F, 32'h204);

    // pc wraps modulo 2^32
    step(0, 1, 32'hFFFF_FFFF);
    step(0, 0, 32'h0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pcp4", pcplus4F, 32'h0);
    step(0, 0, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);

    // two wait states, long enough to saturate the counter
    wmin = 2; wmax = 2;
    repeat (30) step(0, 0, 32'h0);
    chk("sat_cnt", {{(32-CW){1'b0}}, BubbleCnt}, 32'(CMAX));

    // reset in the middle of a wait
    for (int i = 0; i < 5 && !FetchValid; i++) step(0, 0, 32'h0);
    step(0, 0, 32'h0);
    do_reset();
    step(0, 0, 32'h0);
    chk("post_reset_addr", imem_addr, 32'h0);
    chk("post_reset_req", {31'b0, imem_req}, 32'd1);

    // randomized traffic
    sta_pct = 30; pcs_pct = 10; wmin = 0;
    for (int blk = 0; blk < 15; blk++) begin
      wmax = $urandom_range(0, 3);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        else step(-1, -1, $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
